// File: rtl/rr_x_in_pkg.sv
// Shared definitions for the router X-input round-robin arbiter.
// State encoding and modular pointer arithmetic.
package rr_x_in_pkg;

  localparam logic IDLE    = 1'b0;
  localparam logic GRANTED = 1'b1;

  function automatic int unsigned mod_add(
    input int unsigned a,
    input int unsigned b,
    input int unsigned n
  );
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_x_in_arbiter_fpa.sv
// Rotated first-one picker: rotate by ptr, pick lowest set bit,
// map back to a one-hot vector and binary index.
module fpa_x_in_rot #(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
) (
  input  logic [0:IO_SIZE-1] req,
  input  logic [IO_w-1:0]    ptr,
  output logic [0:IO_SIZE-1] onehot,
  output logic [IO_w-1:0]    idx,
  output logic               found
);

  localparam logic [IO_w:0] SIZE = (IO_w+1)'(IO_SIZE);

  logic [0:IO_SIZE-1] rot;
  logic [IO_w-1:0]    pick;
  logic [IO_w:0]      j;
  logic [IO_w:0]      sum;

  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < IO_SIZE; i++) begin
      j = (IO_w+1)'(i) + {1'b0, ptr};
      if (j >= SIZE) j = j - SIZE;
      rot[i] = req[j[IO_w-1:0]];
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < IO_SIZE; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pick  = IO_w'(i);
      end
    end
  end

  always_comb begin
    sum = {1'b0, pick} + {1'b0, ptr};
    if (sum >= SIZE) sum = sum - SIZE;
    idx    = found ? sum[IO_w-1:0] : '0;
    onehot = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_x_in_arbiter.sv
// Round-robin grant arbiter for a router X input port.
// RR_X_IN_FAST_REGRANT_EN: re-arbitrate on release with no bubble.
module rr_x_in_arbiter
  import rr_x_in_pkg::*;
#(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:IO_SIZE-1] request,
  input  logic               release_pkt,
  output logic [0:IO_SIZE-1] grant,
  output logic [IO_w-1:0]    grant_idx,
  output logic               grant_valid
);

  logic               state;
  logic [IO_w-1:0]    ptr;
  logic [IO_w-1:0]    ptr_next;
  logic [0:IO_SIZE-1] pick_oh;
  logic [IO_w-1:0]    pick_idx;
  logic               pick_found;

  assign ptr_next = IO_w'(mod_add(32'(grant_idx), 32'd1, IO_SIZE));

  fpa_x_in_rot #(.IO_SIZE(IO_SIZE), .IO_w(IO_w)) u_pick (
    .req    (request),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

`ifdef RR_X_IN_FAST_REGRANT_EN
  logic [0:IO_SIZE-1] re_oh;
  logic [IO_w-1:0]    re_idx;
  logic               re_found;

  // Current owner is masked so it cannot win twice in a row.
  fpa_x_in_rot #(.IO_SIZE(IO_SIZE), .IO_w(IO_w)) u_repick (
    .req    (request & ~grant),
    .ptr    (ptr_next),
    .onehot (re_oh),
    .idx    (re_idx),
    .found  (re_found)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant       <= pick_oh;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= GRANTED;
          end
        end
        default: begin
          if (release_pkt) begin
            ptr <= ptr_next;
`ifdef RR_X_IN_FAST_REGRANT_EN
            if (re_found) begin
              grant     <= re_oh;
              grant_idx <= re_idx;
            end else begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
`else
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_x_in_arbiter.sv
// Self-checking bench for rr_x_in_arbiter against a behavioural model.
// Honours RR_X_IN_FAST_REGRANT_EN when defined.
module tb_rr_x_in_arbiter;

  localparam int N = 5;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [0:N-1] request;
  logic         release_pkt;
  logic [0:N-1] grant;
  logic [W-1:0] grant_idx;
  logic         grant_valid;

  int passed;
  int total;

  int m_ptr;
  int m_owner;
  bit m_busy;

  rr_x_in_arbiter #(.IO_SIZE(N), .IO_w(W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .release_pkt (release_pkt),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [0:N-1] exp_grant();
    logic [0:N-1] v;
    v = '0;
    if (m_busy) v[m_owner] = 1'b1;
    return v;
  endfunction

  task automatic m_pick(input logic [0:N-1] r);
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (r[p]) begin
        m_owner = p;
        m_busy  = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive(input logic [0:N-1] r, input logic rel);
    logic [0:N-1] masked;
    request     = r;
    release_pkt = rel;
    if (!m_busy) begin
      if (r != '0) m_pick(r);
    end else if (rel) begin
      m_ptr  = (m_owner + 1) % N;
      masked = r;
      masked[m_owner] = 1'b0;
      m_busy = 1'b0;
`ifdef RR_X_IN_FAST_REGRANT_EN
      if (masked != '0) m_pick(masked);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    request     = '0;
    release_pkt = 1'b0;
    m_ptr  = 0;
    m_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [0:N-1] r;
    rst = 1'b1;
    request = '0;
    release_pkt = 1'b0;
    m_ptr = 0;
    m_busy = 1'b0;
    #3;
    total++;
    if (grant !== '0 || grant_idx !== '0 || grant_valid !== 1'b0) begin
      $display("FAIL reset_state: got %b/%0d/%b want 00000/0/0", grant, grant_idx, grant_valid);
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    r = 5'b00100;
    drive(r, 1'b0);
    total++;
    if (grant !== r) begin
      $display("FAIL pre_reset_grant: got %b want %b", grant, r);
    end else passed++;
    #2;
    rst = 1'b1;
    m_ptr = 0;
    m_busy = 1'b0;
    #1;
    total++;
    if (grant !== '0 || grant_idx !== '0 || grant_valid !== 1'b0 || u_dut.ptr !== '0) begin
      $display("FAIL async_reset: got %b/%0d/%b ptr %0d want all zero",
               grant, grant_idx, grant_valid, u_dut.ptr);
    end else passed++;
    #2;
    rst = 1'b0;
    r = 5'b01000;
    drive(r, 1'b0);
    total++;
    if (grant !== r || grant_idx !== 3'd1 || grant_valid !== 1'b1) begin
      $display("FAIL post_reset_grant: got %b/%0d/%b want %b/1/1", grant, grant_idx, grant_valid, r);
    end else passed++;
  endtask

  task automatic test_single();
    logic [0:N-1] r;
    do_reset();
    r = 5'b00100;
    drive(r, 1'b0);
    total++;
    if (grant !== r || grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
      $display("FAIL single_grant: got %b/%0d/%b want 00100/2/1", grant, grant_idx, grant_valid);
    end else passed++;
    for (int k = 0; k < 3; k++) begin
      drive('0, 1'b0);
      total++;
      if (grant !== r || grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
        $display("FAIL single_hold%0d: got %b/%0d/%b want 00100/2/1", k, grant, grant_idx, grant_valid);
      end else passed++;
    end
    drive('0, 1'b1);
    total++;
    if (grant !== '0 || grant_valid !== 1'b0 || u_dut.ptr !== 3'd3) begin
      $display("FAIL single_release: got %b/%b ptr %0d want 00000/0 ptr 3", grant, grant_valid, u_dut.ptr);
    end else passed++;
  endtask

  task automatic test_fairness();
    logic [0:N-1] r;
    do_reset();
    r = 5'b11111;
    drive(r, 1'b0);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (grant_idx !== W'(k % N) || grant_valid !== 1'b1) begin
        $display("FAIL fair_order%0d: got idx %0d valid %b want idx %0d valid 1",
                 k, grant_idx, grant_valid, k % N);
      end else passed++;
      drive(r, 1'b1);
`ifndef RR_X_IN_FAST_REGRANT_EN
      total++;
      if (grant_valid !== 1'b0 || grant !== '0) begin
        $display("FAIL fair_bubble%0d: got %b/%b want 00000/0", k, grant, grant_valid);
      end else passed++;
      drive(r, 1'b0);
`endif
    end
  endtask

  task automatic test_wrap();
    logic [0:N-1] r;
    do_reset();
    drive(5'b00010, 1'b0);
    drive('0, 1'b1);
    total++;
    if (u_dut.ptr !== 3'd4) begin
      $display("FAIL wrap_ptr4: got %0d want 4", u_dut.ptr);
    end else passed++;
    r = 5'b10001;
    drive(r, 1'b0);
    total++;
    if (grant_idx !== 3'd4 || grant !== 5'b00001) begin
      $display("FAIL wrap_grant4: got %b/%0d want 00001/4", grant, grant_idx);
    end else passed++;
    drive('0, 1'b1);
    total++;
    if (u_dut.ptr !== 3'd0 || grant_valid !== 1'b0) begin
      $display("FAIL wrap_ptr0: got ptr %0d valid %b want 0/0", u_dut.ptr, grant_valid);
    end else passed++;
    drive(r, 1'b0);
    total++;
    if (grant_idx !== 3'd0 || grant !== 5'b10000) begin
      $display("FAIL wrap_grant0: got %b/%0d want 10000/0", grant, grant_idx);
    end else passed++;
  endtask

  task automatic test_spurious();
    do_reset();
    drive('0, 1'b1);
    drive('0, 1'b1);
    total++;
    if (grant !== '0 || grant_valid !== 1'b0 || u_dut.ptr !== '0 || u_dut.state !== 1'b0) begin
      $display("FAIL spurious_release: got %b/%b ptr %0d state %b want idle",
               grant, grant_valid, u_dut.ptr, u_dut.state);
    end else passed++;
    drive(5'b00010, 1'b0);
    total++;
    if (grant_idx !== 3'd3 || grant !== 5'b00010 || grant_valid !== 1'b1) begin
      $display("FAIL spurious_next: got %b/%0d/%b want 00010/3/1", grant, grant_idx, grant_valid);
    end else passed++;
  endtask

`ifdef RR_X_IN_FAST_REGRANT_EN
  task automatic test_fast_regrant();
    do_reset();
    drive(5'b11000, 1'b0);
    total++;
    if (grant_idx !== 3'd0) begin
      $display("FAIL fast_first: got idx %0d want 0", grant_idx);
    end else passed++;
    drive(5'b11000, 1'b1);
    total++;
    if (grant !== 5'b01000 || grant_idx !== 3'd1 || grant_valid !== 1'b1) begin
      $display("FAIL fast_regrant: got %b/%0d/%b want 01000/1/1", grant, grant_idx, grant_valid);
    end else passed++;
    do_reset();
    drive(5'b10000, 1'b0);
    drive(5'b10000, 1'b1);
    total++;
    if (grant_valid !== 1'b0 || u_dut.state !== 1'b0) begin
      $display("FAIL fast_to_idle: got valid %b state %b want 0/0", grant_valid, u_dut.state);
    end else passed++;
  endtask
`endif

  task automatic test_random();
    logic [0:N-1] r;
    logic         rel;
    logic [0:N-1] e;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r   = N'($urandom);
      rel = ($urandom_range(0, 2) == 0);
      drive(r, rel);
      e = exp_grant();
      total++;
      if (grant !== e || grant_valid !== m_busy ||
          grant_idx !== (m_busy ? W'(m_owner) : W'(0))) begin
        $display("FAIL random%0d: got %b/%0d/%b want %b/%0d/%b",
                 k, grant, grant_idx, grant_valid, e, m_busy ? m_owner : 0, m_busy);
      end else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    request = '0;
    release_pkt = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_spurious();
`ifdef RR_X_IN_FAST_REGRANT_EN
    test_fast_regrant();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
